// File: rtl/sfq_pkg.sv
// Shared types and helpers for the clocked M-of-N SFQ threshold gate model.
package sfq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_ERROR   = 2'd2
   } sfq_state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_DUP      = 2'd1,
      ERR_HOLD_IN  = 2'd2,
      ERR_HOLD_CLK = 2'd3
   } sfq_err_t;

   // Widest arrival mask the popcount helper accepts.
   localparam int POPCOUNT_MAX_W = 32;

   function automatic int popcount(input logic [POPCOUNT_MAX_W-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/sfq_pulse_detect.sv
// Toggle-to-pulse converter: any level change on a line is one pulse.
// The first clock after reset release only loads the line history, so
// lines already sitting high at release do not count as pulses.
module sfq_pulse_detect #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] tgl,
   output logic [W-1:0] pulse
);

   logic [W-1:0] tgl_q;
   logic         primed_q;

   // Remember last line levels and leave the prime cycle after one clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgl_q    <= '0;
         primed_q <= 1'b0;
      end else begin
         tgl_q    <= tgl;
         primed_q <= 1'b1;
      end
   end

   assign pulse = primed_q ? (tgl ^ tgl_q) : '0;

endmodule

// File: rtl/sfq_threshold_gate.sv
// Clocked M-of-N SFQ threshold gate, cycle-based model.
// Collects input arrivals per gate-clock window, fires the output
// OUT_DELAY cycles after a gate-clock pulse when THRESH inputs arrived,
// and flags duplicate arrivals. Define SFQ_HOLD_CHECK_EN to add hold
// spacing checks between input and gate-clock pulses.
module sfq_threshold_gate
   import sfq_pkg::*;
#(
   parameter int N_IN      = 2,
   parameter int THRESH    = 2,
   parameter int OUT_DELAY = 3,
   parameter int HOLD_CYC  = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IN-1:0]  in_tgl,
   input  logic             sfq_clk_tgl,
   input  logic             clr_err,
   output logic             out_tgl,
   output logic [N_IN-1:0]  arr_mask,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] fire_cnt,
   output logic             hold_viol
);

   logic [N_IN-1:0]      in_pulse;
   logic                 clk_pulse;

   sfq_state_t           state_q, state_d;
   sfq_err_t             code_q, code_d, new_err;
   logic [N_IN-1:0]      arr_q, arr_d, base_mask, win_mask;
   logic [OUT_DELAY-1:0] pipe_q, pipe_d, pipe_base;
   logic                 out_q, out_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 hviol_q, hviol_d;
   logic                 active, fire, dup, hold_in, hold_clk;

   sfq_pulse_detect #(.W(N_IN)) u_in_detect (
      .clk   (clk),
      .rst_n (rst_n),
      .tgl   (in_tgl),
      .pulse (in_pulse)
   );

   sfq_pulse_detect #(.W(1)) u_clk_detect (
      .clk   (clk),
      .rst_n (rst_n),
      .tgl   (sfq_clk_tgl),
      .pulse (clk_pulse)
   );

`ifdef SFQ_HOLD_CHECK_EN
   localparam int HOLD_W = $clog2(HOLD_CYC + 1) + 1;
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYC);

   logic [HOLD_W-1:0] since_clk_q, since_in_q;

   // Saturating distances since the last gate-clock and last input pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         since_clk_q <= HOLD_LIM;
         since_in_q  <= HOLD_LIM;
      end else begin
         if (clk_pulse)
            since_clk_q <= HOLD_W'(1);
         else if (since_clk_q < HOLD_LIM)
            since_clk_q <= since_clk_q + HOLD_W'(1);
         if (|in_pulse)
            since_in_q <= HOLD_W'(1);
         else if (since_in_q < HOLD_LIM)
            since_in_q <= since_in_q + HOLD_W'(1);
      end
   end

   // A same-cycle pair is distance zero and always violates
   assign hold_in  = (|in_pulse) && (clk_pulse || (since_clk_q < HOLD_LIM));
   assign hold_clk = clk_pulse && ((|in_pulse) || (since_in_q < HOLD_LIM));
`else
   assign hold_in  = 1'b0;
   assign hold_clk = 1'b0;
`endif

   // Window bookkeeping, evaluation, delay pipeline and error handling
   always_comb begin
      active    = (state_q != ST_ERROR) || clr_err;
      base_mask = (state_q == ST_ERROR) ? '0 : arr_q;
      pipe_base = (state_q == ST_ERROR) ? '0 : pipe_q;
      fire      = clk_pulse && (popcount(32'(base_mask)) >= THRESH);
      win_mask  = clk_pulse ? '0 : base_mask;
      dup       = |(in_pulse & win_mask);

      new_err = ERR_NONE;
      if (dup)
         new_err = ERR_DUP;
      else if (hold_in)
         new_err = ERR_HOLD_IN;
      else if (hold_clk)
         new_err = ERR_HOLD_CLK;

      state_d = state_q;
      code_d  = code_q;
      arr_d   = arr_q;
      pipe_d  = pipe_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      hviol_d = 1'b0;

      if (active) begin
         arr_d     = win_mask | in_pulse;
         pipe_d    = pipe_base << 1;
         pipe_d[0] = fire;
         if (pipe_base[OUT_DELAY-1]) begin
            out_d = ~out_q;
            cnt_d = cnt_q + CNT_W'(1);
         end
         hviol_d = hold_in || hold_clk;
         if (new_err != ERR_NONE) begin
            state_d = ST_ERROR;
            code_d  = new_err;
         end else begin
            state_d = (arr_d == '0) ? ST_IDLE : ST_PARTIAL;
            code_d  = ERR_NONE;
         end
      end else begin
         arr_d  = '0;
         pipe_d = '0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         code_q  <= ERR_NONE;
         arr_q   <= '0;
         pipe_q  <= '0;
         out_q   <= 1'b0;
         cnt_q   <= '0;
         hviol_q <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         arr_q   <= arr_d;
         pipe_q  <= pipe_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         hviol_q <= hviol_d;
      end
   end

   assign out_tgl   = out_q;
   assign arr_mask  = arr_q;
   assign err       = (state_q == ST_ERROR);
   assign err_code  = code_q;
   assign fire_cnt  = cnt_q;
   assign hold_viol = hviol_q;

endmodule

// File: tb/tb_sfq_threshold_gate.sv
// Self-checking bench for sfq_threshold_gate. DUT "a" uses the default
// 2-of-2 configuration and is tracked by a scoreboard every cycle; DUT "b"
// is a 2-of-3 gate with directed checks. Works with or without
// SFQ_HOLD_CHECK_EN defined.
module tb_sfq_threshold_gate;

`ifdef SFQ_HOLD_CHECK_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  a_in = '0;
   logic        a_clk_tgl = 1'b0;
   logic        clr_err = 1'b0;
   logic        a_out, a_err, a_hv;
   logic [1:0]  a_mask, a_code;
   logic [15:0] a_cnt;
   logic [2:0]  b_in = '0;
   logic        b_clk_tgl = 1'b0;
   logic        b_clr = 1'b0;
   logic        b_out, b_err, b_hv;
   logic [2:0]  b_mask;
   logic [1:0]  b_code;
   logic [15:0] b_cnt;

   typedef struct {
      int   due;
      logic fire;
   } sb_t;

   sb_t         sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        m_out, m_err, m_primed;
   logic [15:0] m_cnt;
   logic [1:0]  m_mask, m_code;
   int          m_hv_cyc, m_last_clk, m_last_in;

   sfq_threshold_gate dut_a (
      .clk(clk), .rst_n(rst_n), .in_tgl(a_in), .sfq_clk_tgl(a_clk_tgl),
      .clr_err(clr_err), .out_tgl(a_out), .arr_mask(a_mask), .err(a_err),
      .err_code(a_code), .fire_cnt(a_cnt), .hold_viol(a_hv)
   );

   sfq_threshold_gate #(.N_IN(3), .THRESH(2), .OUT_DELAY(3), .HOLD_CYC(2), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_tgl(b_in), .sfq_clk_tgl(b_clk_tgl),
      .clr_err(b_clr), .out_tgl(b_out), .arr_mask(b_mask), .err(b_err),
      .err_code(b_code), .fire_cnt(b_cnt), .hold_viol(b_hv)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Retire due scoreboard entries, then compare DUT a against the model
   task automatic checkOutput();
      sb_t t;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         t = sb.pop_front();
         if (t.fire) begin
            m_out = ~m_out;
            m_cnt = m_cnt + 16'd1;
         end
      end
      checkVal("out_tgl", 32'(a_out), 32'(m_out));
      checkVal("fire_cnt", 32'(a_cnt), 32'(m_cnt));
      checkVal("arr_mask", 32'(a_mask), 32'(m_mask));
      checkVal("err", 32'(a_err), 32'(m_err));
      checkVal("err_code", 32'(a_code), 32'(m_code));
      checkVal("hold_viol", 32'(a_hv), 32'(cyc == m_hv_cyc));
   endtask

   // Drive toggles for the next edge, predict its effect, then clock it
   task automatic applyStimulus(input logic [1:0] aip, input logic acp, input logic clr,
                                input logic [2:0] bip, input logic bcp);
      int         e;
      logic [1:0] base;
      logic       fire, dup, hin, hclk, act;
      e         = cyc + 1;
      a_in      = a_in ^ aip;
      a_clk_tgl = a_clk_tgl ^ acp;
      b_in      = b_in ^ bip;
      b_clk_tgl = b_clk_tgl ^ bcp;
      clr_err   = clr;
      if (!m_primed) begin
         m_primed = 1'b1;
      end else begin
         hin  = 1'b0;
         hclk = 1'b0;
         if (HOLD_EN) begin
            hin  = (aip != 2'b00) && (acp || ((e - m_last_clk) < 2));
            hclk = acp && ((aip != 2'b00) || ((e - m_last_in) < 2));
         end
         if (acp) m_last_clk = e;
         if (aip != 2'b00) m_last_in = e;
         act = !m_err || clr;
         if (act) begin
            base = m_err ? 2'b00 : m_mask;
            if (acp) begin
               fire = ($countones(base) >= 2);
               sb.push_back('{due: e + 3, fire: fire});
               base = 2'b00;
            end
            dup    = ((aip & base) != 2'b00);
            m_mask = base | aip;
            if (hin || hclk) m_hv_cyc = e;
            if (dup || hin || hclk) begin
               m_err  = 1'b1;
               m_code = dup ? 2'd1 : (hin ? 2'd2 : 2'd3);
               while (sb.size() > 0 && sb[$].due > e) void'(sb.pop_back());
            end else begin
               m_err  = 1'b0;
               m_code = 2'd0;
            end
         end else begin
            m_mask = 2'b00;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      checkOutput();
      clr_err = 1'b0;
   endtask

   task automatic idleUntil(input int c);
      while (cyc < c - 1) applyStimulus(2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
   endtask

   task automatic doReset(input logic [1:0] a_level);
      rst_n      = 1'b0;
      sb.delete();
      m_out      = 1'b0;
      m_cnt      = '0;
      m_mask     = '0;
      m_err      = 1'b0;
      m_code     = '0;
      m_primed   = 1'b0;
      m_hv_cyc   = -1;
      m_last_clk = -1000;
      m_last_in  = -1000;
      cyc        = -100;
      a_in       = a_level;
      clr_err    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput();
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      // Basic AND firing on DUT a; 2-of-3 no-fire then fire on DUT b
      doReset(2'b00);
      idleUntil(10); applyStimulus(2'b01, 1'b0, 1'b0, 3'b100, 1'b0);
      idleUntil(12); applyStimulus(2'b00, 1'b0, 1'b0, 3'b000, 1'b1);
      idleUntil(14); applyStimulus(2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0, 3'b101, 1'b0);
      checkVal("b_single_no_fire_out", 32'(b_out), 32'd0);
      checkVal("b_single_no_fire_cnt", 32'(b_cnt), 32'd0);
      checkVal("b_mask_two", 32'(b_mask), 32'd5);
      idleUntil(18); applyStimulus(2'b00, 1'b1, 1'b0, 3'b000, 1'b1);
      checkVal("b_mask_cleared", 32'(b_mask), 32'd0);
      idleUntil(21);
      checkVal("b_out_before", 32'(b_out), 32'd0);
      applyStimulus(2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
      checkVal("a_out_at_21", 32'(a_out), 32'd1);
      checkVal("a_cnt_at_21", 32'(a_cnt), 32'd1);
      checkVal("b_out_at_21", 32'(b_out), 32'd1);
      checkVal("b_cnt_at_21", 32'(b_cnt), 32'd1);
      idleUntil(24);

      // Reset asserted while a fire is still in the delay pipeline
      doReset(2'b00);
      idleUntil(10); applyStimulus(2'b01, 1'b0, 1'b0, 3'b000, 1'b0);
      idleUntil(14); applyStimulus(2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
      idleUntil(18); applyStimulus(2'b00, 1'b1, 1'b0, 3'b000, 1'b0);
      applyStimulus(2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
      doReset(2'b00);
      idleUntil(8);
      checkVal("mid_rst_out", 32'(a_out), 32'd0);
      checkVal("mid_rst_cnt", 32'(a_cnt), 32'd0);

      // Duplicate arrival, ignored pulses in ERROR, then clear and recover
      doReset(2'b00);
      idleUntil(10); applyStimulus(2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
      idleUntil(13); applyStimulus(2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
      checkVal("dup_err", 32'(a_err), 32'd1);
      checkVal("dup_code", 32'(a_code), 32'd1);
      idleUntil(15); applyStimulus(2'b01, 1'b0, 1'b0, 3'b000, 1'b0);
      idleUntil(17); applyStimulus(2'b00, 1'b1, 1'b0, 3'b000, 1'b0);
      idleUntil(20); applyStimulus(2'b00, 1'b0, 1'b1, 3'b000, 1'b0);
      checkVal("clr_err_cleared", 32'(a_err), 32'd0);
      idleUntil(23); applyStimulus(2'b01, 1'b0, 1'b0, 3'b000, 1'b0);
      idleUntil(25); applyStimulus(2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
      idleUntil(28); applyStimulus(2'b00, 1'b1, 1'b0, 3'b000, 1'b0);
      idleUntil(33);
      checkVal("recover_cnt", 32'(a_cnt), 32'd1);

      // Lines high through reset release are not arrivals
      doReset(2'b11);
      applyStimulus(2'b00, 1'b0, 1'b0, 3'b000, 1'b0);
      checkVal("prime_mask", 32'(a_mask), 32'd0);
      idleUntil(5); applyStimulus(2'b00, 1'b1, 1'b0, 3'b000, 1'b0);
      idleUntil(10);

      // Input too soon after gate-clock
      doReset(2'b00);
      idleUntil(30); applyStimulus(2'b00, 1'b1, 1'b0, 3'b000, 1'b0);
      applyStimulus(2'b01, 1'b0, 1'b0, 3'b000, 1'b0);
      checkVal("hold_in_code", 32'(a_code), HOLD_EN ? 32'd2 : 32'd0);
      idleUntil(34);

      // Gate-clock too soon after input; clear colliding with a new error
      doReset(2'b00);
      idleUntil(38); applyStimulus(2'b01, 1'b0, 1'b0, 3'b000, 1'b0);
      idleUntil(40); applyStimulus(2'b10, 1'b0, 1'b0, 3'b000, 1'b0);
      applyStimulus(2'b00, 1'b1, 1'b0, 3'b000, 1'b0);
      checkVal("hold_clk_code", 32'(a_code), HOLD_EN ? 32'd3 : 32'd0);
      idleUntil(50); applyStimulus(2'b00, 1'b1, 1'b0, 3'b000, 1'b0);
      applyStimulus(2'b01, 1'b0, 1'b1, 3'b000, 1'b0);
      checkVal("clr_vs_new_err", 32'(a_err), HOLD_EN ? 32'd1 : 32'd0);
      idleUntil(56);

`ifndef SFQ_HOLD_CHECK_EN
      // Back-to-back fires, one output toggle per cycle
      doReset(2'b00);
      idleUntil(10); applyStimulus(2'b11, 1'b0, 1'b0, 3'b000, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(2'b11, 1'b1, 1'b0, 3'b000, 1'b0);
      applyStimulus(2'b00, 1'b1, 1'b0, 3'b000, 1'b0);
      idleUntil(19);
      checkVal("b2b_cnt", 32'(a_cnt), 32'd5);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
